dcache_refill_bridge: RTL

//  Responder side of the D-cache refill handshake (rd_req/rd_rdy/ret_valid/ret_last).

---
 rtl/dcache_bus_pkg.sv | 28 ++
 rtl/dcache_refill_bridge_if.sv | 55 +++++
 rtl/dcache_refill_bridge.sv | 110 +++++++++++
 3 files changed

// File: rtl/dcache_bus_pkg.sv
// Shared definitions for the D-cache refill path: FSM encodings, AXI constants
// and a constant-evaluable log2 helper for sizing fields.
package dcache_bus_pkg;

  // state | meaning
  // IDLE  | bridge free, rd_rdy=1, waiting for a refill request
  // ADDR  | AR beat presented, waiting for arready
  // DATA  | collecting R beats and forwarding them to the cache
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_refill_bridge_if.sv
// Bus bundles around the refill bridge: the cache-side request/return handshake
// and the AXI4 read-address/read-data channels.

interface dcache_req_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_rdy;
  logic              ret_valid;
  logic              ret_last;
  logic [DATA_W-1:0] ret_data;
  logic              resp_err;

  // The D-cache FSM drives requests; the bridge answers.
  modport master (
    output rd_req, rd_addr,
    input  rd_rdy, ret_valid, ret_last, ret_data, resp_err
  );
  modport slave (
    input  rd_req, rd_addr,
    output rd_rdy, ret_valid, ret_last, ret_data, resp_err
  );
endinterface

interface axi_rd_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  // The bridge is the AXI read master; the interconnect is the slave.
  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/dcache_refill_bridge.sv
// D-cache refill bridge: turns one line-refill request into one AXI4 INCR read
// burst and streams each returned word back to the cache one cycle later.
module dcache_refill_bridge
  import dcache_bus_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int ID_W       = 4,
  parameter int AXI_ID     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  dcache_req_if.slave req,
  axi_rd_if.master    axi
);

  localparam int CNT_W = clog2(LINE_WORDS);
  localparam int OFF_W = clog2(LINE_WORDS * DATA_W / 8);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);
  localparam logic [ID_W-1:0]  MY_ID    = ID_W'(AXI_ID);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ret_valid_q, ret_valid_d;
  logic                ret_last_q, ret_last_d;
  logic [DATA_W-1:0]   ret_data_q, ret_data_d;
  logic                resp_err_q, resp_err_d;

  logic beat_acc;
  logic beat_last;

  // A beat counts only when it carries our ID; foreign beats are drained silently.
  assign beat_acc  = (state_q == ST_DATA) && axi.rvalid && (axi.rid == MY_ID);
  assign beat_last = (cnt_q == LAST_CNT);

  // Registered state and output holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      araddr_q    <= '0;
      cnt_q       <= '0;
      ret_valid_q <= 1'b0;
      ret_last_q  <= 1'b0;
      ret_data_q  <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      araddr_q    <= araddr_d;
      cnt_q       <= cnt_d;
      ret_valid_q <= ret_valid_d;
      ret_last_q  <= ret_last_d;
      ret_data_q  <= ret_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // Next-state logic: address latch, beat counting and error tracking.
  always_comb begin
    state_d     = state_q;
    araddr_d    = araddr_q;
    cnt_d       = cnt_q;
    ret_valid_d = 1'b0;
    ret_last_d  = 1'b0;
    ret_data_d  = ret_data_q;
    resp_err_d  = resp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req.rd_req) begin
          araddr_d            = req.rd_addr;
          araddr_d[OFF_W-1:0] = '0;
          cnt_d               = '0;
          state_d             = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (axi.arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (beat_acc) begin
          ret_valid_d = 1'b1;
          ret_data_d  = axi.rdata;
          ret_last_d  = beat_last;
          cnt_d       = cnt_q + CNT_W'(1);
          // A misplaced RLAST is reported but the local count still ends the burst.
          if ((axi.rresp != AXI_RESP_OKAY) || (axi.rlast != beat_last)) resp_err_d = 1'b1;
          if (beat_last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req.rd_rdy    = (state_q == ST_IDLE);
  assign req.ret_valid = ret_valid_q;
  assign req.ret_last  = ret_last_q;
  assign req.ret_data  = ret_data_q;
  assign req.resp_err  = resp_err_q;

  assign axi.arid    = MY_ID;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = 8'(LINE_WORDS - 1);
  assign axi.arsize  = 3'(clog2(DATA_W / 8));
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arvalid = (state_q == ST_ADDR);
  assign axi.rready  = (state_q == ST_DATA);

endmodule
